// File: rtl/display_pkg.sv
// Shared defaults and polarity helper for the seven-segment scan driver.
package display_pkg;

  localparam int DEF_DIGITS  = 4;
  localparam int DEF_DIGIT_W = 4;

  typedef logic [$clog2(DEF_DIGITS)-1:0] digit_idx_t;

  // Maps a logical "on" to the pin level for the configured polarity.
  function automatic logic drive_level(input logic active, input bit active_low);
    return active ^ active_low;
  endfunction

endpackage

// File: rtl/digit_select_mux.sv
// DIGITS-way combinational select of a DIGIT_W-bit field from a flat bus.
module digit_select_mux #(
  parameter int DIGITS  = 4,
  parameter int DIGIT_W = 4
) (
  input  logic [DIGITS*DIGIT_W-1:0]  bus,
  input  logic [$clog2(DIGITS)-1:0]  sel,
  output logic [DIGIT_W-1:0]         value
);

  localparam int SEL_W = $clog2(DIGITS);

  always_comb begin
    value = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (sel == SEL_W'(i)) value = bus[i*DIGIT_W +: DIGIT_W];
    end
  end

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexed seven-segment scan driver: frame snapshot, guarded
// one-hot anodes and leading-zero blanking, all outputs registered.
module display_scan_mux
  import display_pkg::*;
#(
  parameter int DIGITS      = DEF_DIGITS,
  parameter int DIGIT_W     = DEF_DIGIT_W,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 2,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      lz_en,
  input  logic [DIGITS*DIGIT_W-1:0] data,
  input  logic [DIGITS-1:0]         dp_in,
  output logic [DIGIT_W-1:0]        digit_out,
  output logic [DIGITS-1:0]         an,
  output logic                      dp,
  output logic [$clog2(DIGITS)-1:0] sel,
  output logic                      frame
);

  localparam int PRE_W = $clog2(REFRESH_DIV + 1);
  localparam int SEL_W = $clog2(DIGITS);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [PRE_W-1:0] GUARD_V  = PRE_W'(GUARD);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_OFF  = ACTIVE_LOW ? '1 : '0;

  logic [PRE_W-1:0]          pre;
  logic [SEL_W-1:0]          idx;
  logic [DIGITS*DIGIT_W-1:0] snap_data;
  logic [DIGITS-1:0]         snap_dp;
  logic                      primed;

  logic                      slot_end;
  logic                      frame_wrap;
  logic                      load;
  logic [DIGITS-1:0]         blank;
  logic                      lit;
  logic [DIGIT_W-1:0]        cur_digit;
  logic [0:0]                cur_dp;
  logic [DIGITS-1:0]         an_next;
  logic                      dp_next;

  assign slot_end   = en && (pre == PRE_LAST);
  assign frame_wrap = slot_end && (idx == IDX_LAST);
  assign load       = frame_wrap || !primed;

  digit_select_mux #(.DIGITS(DIGITS), .DIGIT_W(DIGIT_W)) u_digit_mux (
    .bus   (snap_data),
    .sel   (idx),
    .value (cur_digit)
  );

  digit_select_mux #(.DIGITS(DIGITS), .DIGIT_W(1)) u_dp_mux (
    .bus   (snap_dp),
    .sel   (idx),
    .value (cur_dp)
  );

  // A digit is blank when it and every more significant digit are zero.
  always_comb begin
    logic upper_zero;
    blank      = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero && (snap_data[i*DIGIT_W +: DIGIT_W] == '0);
      blank[i]   = lz_en && upper_zero;
    end
  end

  always_comb begin
    lit = en && (pre >= GUARD_V) && !blank[idx];
    for (int i = 0; i < DIGITS; i++) begin
      an_next[i] = drive_level(lit && (idx == SEL_W'(i)), ACTIVE_LOW);
    end
    dp_next = drive_level(lit && cur_dp[0], ACTIVE_LOW);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre       <= '0;
      idx       <= '0;
      snap_data <= '0;
      snap_dp   <= '0;
      primed    <= 1'b0;
      sel       <= '0;
      digit_out <= '0;
      frame     <= 1'b0;
      an        <= AN_OFF;
      dp        <= ACTIVE_LOW;
    end else begin
      if (!en || pre == PRE_LAST) pre <= '0;
      else                        pre <= pre + 1'b1;

      if (slot_end) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;

      primed <= 1'b1;
      if (load) begin
        snap_data <= data;
        snap_dp   <= dp_in;
      end
      frame <= load;

      // Index and value freeze on the display while scanning is paused.
      if (en) begin
        sel       <= idx;
        digit_out <= cur_digit;
      end
      an <= an_next;
      dp <= dp_next;
    end
  end

endmodule

// File: tb/tb_display_scan_mux.sv
// Self-checking bench for display_scan_mux: directed scenarios plus random
// stimulus checked every cycle against a behavioural slot/frame model.
module tb_display_scan_mux;

  localparam int D  = 4;
  localparam int W  = 4;
  localparam int RD = 8;
  localparam int G  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        lz_en;
  logic [15:0] data;
  logic [3:0]  dp_in;
  logic [3:0]  digit_out;
  logic [3:0]  an;
  logic        dp;
  logic [1:0]  sel;
  logic        frame;

  display_scan_mux #(
    .DIGITS(D), .DIGIT_W(W), .REFRESH_DIV(RD), .GUARD(G), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .lz_en(lz_en), .data(data), .dp_in(dp_in),
    .digit_out(digit_out), .an(an), .dp(dp), .sel(sel), .frame(frame)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: position within the slot, digit being scanned, frame snapshot.
  int          m_pos;
  int          m_digit;
  logic [15:0] m_snap;
  logic [3:0]  m_snap_dp;
  bit          m_primed;
  logic [3:0]  e_an;
  logic [3:0]  e_dig;
  logic        e_dp;
  logic [1:0]  e_sel;
  logic        e_frame;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int digit_of(input logic [15:0] v, input int i);
    return int'((v >> (4 * i)) & 16'hF);
  endfunction

  function automatic bit is_blank(input int i);
    return lz_en && (i != 0) && ((m_snap >> (4 * i)) == 16'h0);
  endfunction

  task automatic model_reset();
    m_pos = 0; m_digit = 0; m_snap = '0; m_snap_dp = '0; m_primed = 0;
    e_an = 4'hF; e_dp = 1'b1; e_dig = '0; e_sel = '0; e_frame = 1'b0;
  endtask

  task automatic check_all(input string ph);
    check({ph, ".an"}, an, e_an);
    check({ph, ".dp"}, dp, e_dp);
    check({ph, ".digit"}, digit_out, e_dig);
    check({ph, ".sel"}, sel, e_sel);
    check({ph, ".frame"}, frame, e_frame);
  endtask

  task automatic step(input string ph);
    bit on;
    bit new_frame;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      on = en && (m_pos >= G) && !is_blank(m_digit);
      e_an = on ? ~(4'b0001 << m_digit) : 4'hF;
      e_dp = on ? ~m_snap_dp[m_digit] : 1'b1;
      if (en) begin
        e_sel = 2'(m_digit);
        e_dig = 4'(digit_of(m_snap, m_digit));
      end
      new_frame = !m_primed || (en && m_pos == RD - 1 && m_digit == D - 1);
      e_frame = new_frame;
      if (new_frame) begin
        m_snap = data;
        m_snap_dp = dp_in;
      end
      m_primed = 1;
      if (!en) m_pos = 0;
      else if (m_pos == RD - 1) begin
        m_pos = 0;
        m_digit = (m_digit + 1) % D;
      end else m_pos++;
    end
    #1;
    check_all(ph);
  endtask

  task automatic run(input string ph, input int n);
    for (int k = 0; k < n; k++) step(ph);
  endtask

  task automatic run_until(input string ph, input int d, input int p);
    for (int k = 0; k < 100 && !(m_digit == d && m_pos == p); k++) step(ph);
    check({ph, ".reach"}, (m_digit == d && m_pos == p), 1);
  endtask

  function automatic logic [15:0] rand_data();
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < 4; i++)
      if ($urandom_range(0, 1) == 1) v[4*i +: 4] = 4'($urandom_range(0, 15));
    return v;
  endfunction

  initial begin
    rst = 1'b1; en = 1'b1; lz_en = 1'b0; data = 16'h1234; dp_in = 4'b0000;
    model_reset();

    // Reset values
    run("reset", 2);
    check("reset.an_all_off", an, 4'b1111);

    // Release: snapshot load with frame pulse, then digit 0 value
    rst = 1'b0;
    step("release");
    check("release.frame_pulse", frame, 1);
    step("release");
    check("release.first_digit", digit_out, 4);
    check("release.frame_once", frame, 0);

    // Full scan with decimal points
    dp_in = 4'b0101;
    run("scan", 40);

    // Frame coherence: new data mid-frame only appears in next frame
    run_until("coh", 1, 3);
    data = 16'h5678;
    run("coh", 40);

    // Leading zeros
    lz_en = 1'b1; data = 16'h0040;
    run("lz40", 40);
    data = 16'h0000;
    run("lz00", 40);
    lz_en = 1'b0; data = 16'h1234;
    run("lzoff", 40);

    // Enable drop mid-slot and recovery with guard
    run_until("en", 1, 4);
    en = 1'b0;
    step("en_off");
    check("en_off.an", an, 4'b1111);
    check("en_off.sel", sel, 1);
    run("en_off", 3);
    en = 1'b1;
    run("en_on", 12);

    // Asynchronous reset mid-frame
    run_until("rstmid", 2, 3);
    rst = 1'b1;
    #1;
    check("rstmid.an", an, 4'b1111);
    check("rstmid.dp", dp, 1);
    check("rstmid.sel", sel, 0);
    check("rstmid.digit", digit_out, 0);
    model_reset();
    data = 16'h9abc;
    run("rstmid", 2);
    rst = 1'b0;
    run("rstmid_rel", 40);

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      en = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 40) == 0) lz_en = ~lz_en;
      if ($urandom_range(0, 10) == 0) data = rand_data();
      if ($urandom_range(0, 10) == 0) dp_in = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 600) == 0) begin
        rst = 1'b1;
        #1;
        check("rand.async_an", an, 4'b1111);
        model_reset();
        step("rand_rst");
        rst = 1'b0;
      end
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/display_scan_mux.md
# display_scan_mux

Time-multiplexed driver for an N-digit seven-segment display, between the timer's BCD counter outputs and the segment decoder. It holds a frame-coherent snapshot of all digit values and scans one digit per refresh slot. It drives one-hot anodes with a guard (ghosting) interval, and can blank leading zeros. It generalises the fixed 4-bit 4:1 digit select to parametric width and depth, with its own scan sequencing.

## Interface
- DIGITS, 4: number of digits; ≥2.
- DIGIT_W, 4: bits per digit value.
- REFRESH_DIV, 100000: clock cycles per digit slot; > GUARD.
- GUARD, 2: cycles at the start of each slot with all anodes off; ≥0.
- ACTIVE_LOW, 1: 1 means AN and DP are active-low; 0 means active-high.
- Clocking: one clock; reset is asynchronous and active-high.
- CLK  in  1  clock.
- RST  in  1  asynchronous active-high reset.
- EN  in  1  scan enable.
- LZ_EN  in  1  leading-zero suppression enable.
- DATA  in  DIGITS*DIGIT_W  digit values; digit i = DATA[i*DIGIT_W +: DIGIT_W]; digit 0 is least significant.
- DP_IN  in  DIGITS  decimal point request per digit.
- DIGIT_OUT  out  DIGIT_W  value of the currently scanned digit.
- AN  out  DIGITS  one-hot anode enables, polarity per ACTIVE_LOW.
- DP  out  1  decimal point of the current digit, polarity per ACTIVE_LOW.
- SEL  out  $clog2(DIGITS)  index of the current digit.
- FRAME  out  1  one-cycle pulse when a new snapshot is loaded.

## Operation
- **Prescaler `pre`:** counts 0..REFRESH_DIV-1 while EN=1, then wraps to 0. While EN=0 it is held at 0.
- **Digit index `idx`:** advances when `pre` = REFRESH_DIV-1 and EN=1. It wraps from DIGITS-1 to 0.
- **Snapshot register:** holds DATA and DP_IN. It loads on the cycle where `idx` wraps DIGITS-1→0. It also loads on the first clock edge after RST deasserts, via an internal `primed` flag that reset clears. DATA changes mid-frame are not displayed until the next frame.
- **Blank mask:**
  - Bit i is set when LZ_EN=1, i≠0, and snapshot digits i..DIGITS-1 are all zero.
  - Digit 0 is never blanked.
  - The mask is computed combinationally from the snapshot and the live LZ_EN.
- **Anode output:** AN[idx] is active when EN=1, `pre` ≥ GUARD and blank[idx]=0. All other AN bits are inactive.
- **Digit outputs:** DIGIT_OUT = snapshot digit[idx]. DP = snapshot DP_IN[idx] gated by the same condition as AN[idx].
- **EN=0:** all AN inactive and DP inactive. SEL and DIGIT_OUT hold. When EN returns to 1, the current slot restarts from `pre`=0, including its guard interval.

## Timing
- AN, DP, DIGIT_OUT, SEL and FRAME are registered. Each reflects the `pre`/`idx` state of the previous cycle, i.e. a 1-cycle latency.
- Slot length is REFRESH_DIV cycles. The anode is on for REFRESH_DIV-GUARD cycles per slot. A frame is DIGITS*REFRESH_DIV cycles.
- FRAME is high for the cycle after each snapshot load, including the post-reset load.
- **Reset values (all outputs):**
  - `pre`=0, `idx`=0, SEL=0, DIGIT_OUT=0, FRAME=0.
  - Snapshot = 0, `primed`=0.
  - AN all inactive (all 1s if ACTIVE_LOW), DP inactive.
- Reset asserted mid-slot or mid-frame: outputs take their reset values immediately (asynchronously). The scan restarts at digit 0 after release.
- EN and the frame wrap in the same cycle: the wrap happens only if EN=1. No snapshot is loaded while EN=0.
- LZ_EN changing mid-slot takes effect on the next cycle.

## Structure
- Package `display_pkg`: default DIGITS/DIGIT_W constants, the anode/DP polarity helper function, and the `digit_idx_t` typedef sized $clog2(DIGITS) at the default.
- Sub-module `digit_select_mux`: parametrised DIGITS-way, DIGIT_W-bit combinational select, with a flat bus in and an index in. It is used for DIGIT_OUT and for the DP bit.
- The top level contains the prescaler, index counter, snapshot, primed flag, blank mask and output registers.

## Test plan
All scenarios use DIGITS=4, DIGIT_W=4, REFRESH_DIV=8, GUARD=2, ACTIVE_LOW=1.
1. **Reset:** RST=1 → AN=4'b1111, DP=1, DIGIT_OUT=0, SEL=0, FRAME=0. Release with DATA=16'h1234 → FRAME pulses once, then DIGIT_OUT=4.
2. **Scan:** EN=1, LZ_EN=0, DATA=16'h1234 → SEL steps 0,1,2,3,0 every 8 cycles and DIGIT_OUT steps 4,3,2,1. AN[i]=0 for exactly 6 of the 8 cycles of slot i, and AN=4'b1111 for the first 2.
3. **Frame coherence:** change DATA to 16'h5678 during slot 1 → slots 2 and 3 still show 2 and 1. The next frame shows 8,7,6,5, with FRAME pulsing at the wrap.
4. **Leading zeros:**
   - LZ_EN=1, DATA=16'h0040 → AN stays 4'b1111 through slots 3 and 2, digit 1 shows 4, digit 0 shows 0.
   - DATA=16'h0000 → only AN[0] is ever active.
5. **Enable:** drop EN at `pre`=4 of slot 1 → AN=4'b1111 on the next cycle and SEL holds at 1. Raise EN → 2 guard cycles, then 6 active cycles of slot 1.
6. **Reset mid-frame:** assert RST during slot 2 → outputs are at reset values immediately. After release, DATA is re-snapshotted and scanning starts at SEL=0.
